// File: rtl/min_index_pkg.sv
// Shared definitions for the sequential min/max index selector and the colour classifier.
package min_index_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_MIN = 1'b0;
    localparam logic MODE_MAX = 1'b1;

endpackage

// File: rtl/min_index_cmp.sv
// Candidate-accept logic: take is high when the enabled candidate beats the running best.
module min_index_cmp
    import min_index_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] value,
    input  logic [W-1:0] best,
    input  logic         have_best,
    input  logic         enable,
    input  logic         mode,
    output logic         take
);

    logic better;

    // Strict compare keeps the lowest index on ties.
    always_comb begin
        better = 1'b0;
        if (mode == MODE_MAX) begin
            better = (value > best);
        end else begin
            better = (value < best);
        end
        take = enable && (!have_best || better);
    end

endmodule

// File: rtl/min_index_seq.sv
// Sequential N-channel min/max index search: one channel per clock, start/busy/done handshake.
module min_index_seq
    import min_index_pkg::*;
#(
    parameter  int unsigned N    = 6,
    parameter  int unsigned W    = 8,
    localparam int unsigned IDXW = $clog2(N)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              mode,
    input  logic [N-1:0]      mask,
    input  logic [N*W-1:0]    data,
    output logic              busy,
    output logic              done,
    output logic [IDXW-1:0]   index,
    output logic [W-1:0]      value,
    output logic              found
);

    localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

    state_t                  state;
    logic [IDXW-1:0]         ptr;
    logic [N-1:0][W-1:0]     data_q;
    logic [N-1:0]            mask_q;
    logic                    mode_q;
    logic [W-1:0]            best;
    logic [IDXW-1:0]         best_idx;
    logic                    have_best;
    logic [W-1:0]            cur;
    logic                    cur_en;
    logic                    take;

    always_comb begin
        cur    = data_q[ptr];
        cur_en = mask_q[ptr];
    end

    min_index_cmp #(.W(W)) u_cmp (
        .value     (cur),
        .best      (best),
        .have_best (have_best),
        .enable    (cur_en),
        .mode      (mode_q),
        .take      (take)
    );

    // FSM, pointer, captured operands and result registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ptr       <= '0;
            data_q    <= '0;
            mask_q    <= '0;
            mode_q    <= MODE_MIN;
            best      <= '0;
            best_idx  <= '0;
            have_best <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            index     <= '0;
            value     <= '0;
            found     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        data_q    <= data;
                        mask_q    <= mask;
                        mode_q    <= mode;
                        best      <= '0;
                        best_idx  <= '0;
                        have_best <= 1'b0;
                        ptr       <= '0;
                        busy      <= 1'b1;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (take) begin
                        best      <= cur;
                        best_idx  <= ptr;
                        have_best <= 1'b1;
                    end
                    // Results are published only once the last channel is folded in.
                    if (ptr == LAST) begin
                        index <= take ? ptr : best_idx;
                        value <= take ? cur : best;
                        found <= have_best | take;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        ptr <= ptr + IDXW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_min_index_seq.sv
// Directed testbench for min_index_seq with N=6, W=8 and hand-computed expectations.
module tb_min_index_seq;

    localparam int unsigned N    = 6;
    localparam int unsigned W    = 8;
    localparam int unsigned IDXW = 3;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              start;
    logic              mode;
    logic [N-1:0]      mask;
    logic [N*W-1:0]    data;
    logic              busy;
    logic              done;
    logic [IDXW-1:0]   index;
    logic [W-1:0]      value;
    logic              found;

    int vectors     = 0;
    int miscompares = 0;

    min_index_seq #(.N(N), .W(W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .mode    (mode),
        .mask    (mask),
        .data    (data),
        .busy    (busy),
        .done    (done),
        .index   (index),
        .value   (value),
        .found   (found)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] pack6(input int c0, input int c1, input int c2,
                                          input int c3, input int c4, input int c5);
        return {8'(c5), 8'(c4), 8'(c3), 8'(c2), 8'(c1), 8'(c0)};
    endfunction

    // Present a start for one edge; returns at the first negedge after the capture edge.
    task automatic go(input logic [47:0] d, input logic [5:0] m, input logic md);
        data  = d;
        mask  = m;
        mode  = md;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Waits (bounded) for the done cycle; lat counts cycles from the start edge.
    task automatic wait_done(input string tag, output int lat);
        int n;
        n = 1;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (done !== 1'b1) check({tag, "_timeout"}, 32'(done), 32'd1);
        lat = n - 1;
    endtask

    task automatic search(input string tag, input logic [47:0] d, input logic [5:0] m,
                          input logic md, input int eidx, input int evalue, input int efound);
        int lat;
        go(d, m, md);
        wait_done(tag, lat);
        check({tag, "_latency"}, 32'(lat), 32'd6);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_index"}, 32'(index), 32'(eidx));
        check({tag, "_value"}, 32'(value), 32'(evalue));
        check({tag, "_found"}, 32'(found), 32'(efound));
        @(negedge clock);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_busy_fall"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int pulses;
        int pn [4];
        int pi [4];
        int pv [4];
        int seen;
        int lat;

        reset_n = 1'b0;
        start   = 1'b0;
        mode    = 1'b0;
        mask    = '0;
        data    = '0;
        @(negedge clock);
        @(negedge clock);
        check("reset_busy",  32'(busy),  32'd0);
        check("reset_done",  32'(done),  32'd0);
        check("reset_index", 32'(index), 32'd0);
        check("reset_value", 32'(value), 32'd0);
        check("reset_found", 32'(found), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        search("min_all", pack6(40, 12, 90, 12, 7, 55), 6'b111111, 1'b0, 4, 7, 1);
        search("max_tie", pack6(200, 31, 200, 5, 9, 1), 6'b111111, 1'b1, 0, 200, 1);
        search("min_tie", pack6(200, 31, 200, 5, 9, 1), 6'b111111, 1'b0, 5, 1, 1);
        search("mask",    pack6(3, 50, 60, 2, 70, 80),  6'b110110, 1'b0, 1, 50, 1);
        search("mask0",   pack6(3, 50, 60, 2, 70, 80),  6'b000000, 1'b0, 0, 0, 0);
        search("mask_hi", pack6(3, 50, 60, 2, 70, 80),  6'b000110, 1'b1, 2, 60, 1);

        // Continuous start: searches every 8 cycles; data change after capture is ignored.
        pulses = 0;
        data   = pack6(40, 12, 90, 12, 7, 55);
        mask   = 6'b111111;
        mode   = 1'b0;
        start  = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clock);
            if (n == 10) data = pack6(1, 2, 3, 4, 5, 6);
            if (done === 1'b1 && pulses < 4) begin
                pn[pulses] = n;
                pi[pulses] = int'(index);
                pv[pulses] = int'(value);
                pulses++;
            end
            if (n == 24) start = 1'b0;
        end
        check("rep_pulses", 32'(pulses), 32'd3);
        if (pulses == 3) begin
            check("rep_first",  32'(pn[0]), 32'd7);
            check("rep_gap1",   32'(pn[1] - pn[0]), 32'd8);
            check("rep_gap2",   32'(pn[2] - pn[1]), 32'd8);
            check("rep_idx2",   32'(pi[1]), 32'd4);
            check("rep_val2",   32'(pv[1]), 32'd7);
            check("rep_idx3",   32'(pi[2]), 32'd0);
            check("rep_val3",   32'(pv[2]), 32'd1);
        end
        repeat (3) @(negedge clock);
        check("rep_idle", 32'(busy), 32'd0);

        // Reset in the third SCAN cycle clears everything asynchronously.
        search("pre_reset", pack6(200, 31, 200, 5, 9, 1), 6'b111111, 1'b1, 0, 200, 1);
        go(pack6(9, 8, 7, 6, 5, 4), 6'b111111, 1'b1);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_index", 32'(index), 32'd0);
        check("rst_value", 32'(value), 32'd0);
        check("rst_found", 32'(found), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clock);
            if (done === 1'b1) seen++;
        end
        check("rst_no_done", 32'(seen), 32'd0);
        search("post_reset", pack6(9, 8, 7, 6, 5, 4), 6'b011111, 1'b1, 0, 9, 1);

        // Start during DONE is dropped; start in the following IDLE cycle is taken.
        go(pack6(3, 50, 60, 2, 70, 80), 6'b110110, 1'b0);
        wait_done("b2b_first", lat);
        check("b2b_first_index", 32'(index), 32'd1);
        data  = pack6(10, 20, 30, 40, 50, 5);
        mask  = 6'b111111;
        mode  = 1'b1;
        start = 1'b1;
        check("b2b_busy_done", 32'(busy), 32'd1);
        @(negedge clock);
        check("b2b_ignored_busy", 32'(busy), 32'd0);
        check("b2b_ignored_done", 32'(done), 32'd0);
        @(negedge clock);
        start = 1'b0;
        check("b2b_accepted", 32'(busy), 32'd1);
        wait_done("b2b_second", lat);
        check("b2b_second_latency", 32'(lat), 32'd6);
        check("b2b_second_index", 32'(index), 32'd4);
        check("b2b_second_value", 32'(value), 32'd50);
        @(negedge clock);
        check("b2b_second_pulse", 32'(done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/min_index_seq.md
# min_index_seq

Parametrised, sequential successor to the six-way combinational minimum-index selector used in colour classification. It captures N unsigned W-bit channel values in one cycle, with a per-channel enable mask and a min/max mode. It scans them one channel per clock and reports the winning index, its value and a found flag with a start/busy/done handshake. It sits between the sensor distance calculators and the facelet colour classifier, where it replaces the fixed six-input comparator tree.

## Interface
- N, 6, number of channels; legal range 2..64
- W, 8, channel value width in bits; unsigned
- IDXW, $clog2(N), derived localparam; index width, never overridden
- clock  input  1  system clock; all state updates on the rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request a search; sampled only in IDLE
- mode  input  1  0 = search for minimum, 1 = search for maximum; captured with start
- mask  input  N  bit k = 1 enables channel k; captured with start
- data  input  N*W  channel k occupies data[k*W +: W]; captured with start
- busy  output  1  high in SCAN and DONE
- done  output  1  one-cycle pulse in DONE
- index  output  IDXW  index of the winning channel
- value  output  W  value of the winning channel
- found  output  1  1 if at least one channel was enabled in the last search

## Operation
- States: IDLE, SCAN, DONE.
- IDLE:
  - start=1 captures data, mask and mode into internal registers.
  - Clears the working best and pointer, then goes to SCAN with ptr=0.
  - start=0 keeps the block in IDLE.
- SCAN: each cycle evaluates channel ptr.
  - Candidate is accepted if mask[ptr]=1 and either no best exists yet, or (mode=0 and data<best) or (mode=1 and data>best).
  - Comparison is strict, so on ties the lowest index wins.
  - On the last channel (ptr=N-1), the final result is written to index/value/found and the state goes to DONE. Otherwise ptr increments.
- DONE: done=1 for exactly one cycle, then unconditional return to IDLE.
- start is ignored while busy=1; a start in DONE is not queued.
- All channels masked: found=0, index=0, value=0.
- index/value/found hold their last result until the next search reaches its final channel; they never show partial results.
- Inputs may change after the capture edge without affecting the running search.
- Reset (any time, including mid-SCAN): state IDLE, ptr=0, busy=0, done=0, index=0, value=0, found=0, captured registers cleared. The aborted search produces no done pulse.

## Timing
- Start accepted at edge E0. Channels 0..N-1 are evaluated at edges E1..EN. Result is registered at EN.
- done is high during the cycle after EN, and the result is valid in that same cycle. Latency from the start edge to the done cycle is N cycles.
- Return to IDLE at E(N+1). Minimum start-to-start period is N+2 cycles.
- busy rises in the cycle after E0 and falls after E(N+1).
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package min_index_pkg holds the state enum (IDLE/SCAN/DONE) and the mode constants MODE_MIN=0 and MODE_MAX=1. The package is reused by the classifier.
- One sub-module, min_index_cmp: combinational candidate-accept logic with inputs value, best, have_best, enable, mode and output take. It is instantiated once in the datapath.
- Top holds the FSM, pointer counter, captured registers and result registers.

## Test plan
All scenarios use N=6, W=8.
- Min, all enabled: data={ch0..ch5}={40,12,90,12,7,55}, mask=111111, mode=0 -> done 6 cycles after the start edge; index=4, value=7, found=1.
- Tie and max: data={200,31,200,5,9,1}, mode=1, mask=111111 -> index=0, value=200. Same data with mode=0 -> index=5, value=1.
- Mask: data={3,50,60,2,70,80}, mask=110110 (ch0 and ch3 disabled), mode=0 -> index=1, value=50. With mask=000000 -> found=0, index=0, value=0, done still pulses.
- Handshake: hold start=1 continuously -> searches repeat every 8 cycles. done is a single-cycle pulse each time. Changing data mid-SCAN does not alter the result.
- Reset mid-SCAN: assert reset_n=0 at the 3rd SCAN cycle -> all outputs 0 asynchronously and no done pulse. A new start after release gives a correct result with prior result registers cleared.
- Back-to-back: issue a second start in the DONE cycle -> ignored, busy stays high. A start in the following IDLE cycle is accepted.
